tinyqv_mem_serdes: RTL

TINYQV_MEM_SERDES -- requirements
Module: tinyqv_mem_serdes

---
 rtl/tinyqv_mem_serdes.sv | 133 +++++++++++++
 1 files changed

// File: rtl/tinyqv_mem_serdes.sv
// Nibble-serial to word-parallel bridge between the TinyQV core and a 32-bit load/store bus.
// Stores are collected one nibble per clk; loads are buffered and replayed aligned to the core counter.
module tinyqv_mem_serdes #(
  parameter int ADDR_BITS = 28
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [2:0]           counter,
  input  logic                 address_ready,
  input  logic [ADDR_BITS-1:0] addr_in,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic [2:0]           mem_op,
  input  logic [3:0]           store_nibble,
  output logic [3:0]           load_nibble,
  output logic                 load_data_ready,
  output logic [ADDR_BITS-1:0] bus_addr,
  output logic [1:0]           bus_size,
  output logic [31:0]          bus_wdata,
  output logic                 bus_read,
  output logic                 bus_write,
  input  logic                 bus_ack,
  input  logic [31:0]          bus_rdata,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ST_COLLECT = 3'd1,
    ST_REQ     = 3'd2,
    LD_REQ     = 3'd3,
    LD_HOLD    = 3'd4,
    LD_STREAM  = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] load_buf;
  logic        last_nibble;
  logic [4:0]  nibble_base;
  logic        unused_mem_op;

  assign last_nibble   = (counter == 3'd7);
  assign nibble_base   = {counter, 2'b00};
  assign unused_mem_op = mem_op[2];

  // Replay is combinational on counter so the core sees nibble N exactly at counter N.
  assign load_nibble = load_data_ready ? load_buf[nibble_base +: 4] : 4'd0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      bus_read        <= 1'b0;
      bus_write       <= 1'b0;
      busy            <= 1'b0;
      load_data_ready <= 1'b0;
      bus_addr        <= '0;
      bus_size        <= 2'b00;
      bus_wdata       <= 32'd0;
      load_buf        <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (address_ready && (is_load || is_store)) begin
            bus_addr <= addr_in;
            bus_size <= mem_op[1:0];
            busy     <= 1'b1;
            // A load takes priority when the core flags both classes.
            if (is_load) begin
              state    <= LD_REQ;
              bus_read <= 1'b1;
            end else begin
              state <= ST_COLLECT;
            end
          end
        end

        ST_COLLECT: begin
          bus_wdata[nibble_base +: 4] <= store_nibble;
          if (last_nibble) begin
            state     <= ST_REQ;
            bus_write <= 1'b1;
          end
        end

        ST_REQ: begin
          if (bus_ack) begin
            state     <= IDLE;
            bus_write <= 1'b0;
            busy      <= 1'b0;
          end
        end

        LD_REQ: begin
          if (bus_ack) begin
            load_buf <= bus_rdata;
            bus_read <= 1'b0;
            // An ack on counter 7 can stream straight away; otherwise wait for the next nibble 0.
            if (last_nibble) begin
              state           <= LD_STREAM;
              load_data_ready <= 1'b1;
            end else begin
              state <= LD_HOLD;
            end
          end
        end

        LD_HOLD: begin
          if (last_nibble) begin
            state           <= LD_STREAM;
            load_data_ready <= 1'b1;
          end
        end

        LD_STREAM: begin
          if (last_nibble) begin
            state           <= IDLE;
            load_data_ready <= 1'b0;
            busy            <= 1'b0;
          end
        end

        default: begin
          state           <= IDLE;
          bus_read        <= 1'b0;
          bus_write       <= 1'b0;
          busy            <= 1'b0;
          load_data_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
